dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 125 ++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder data-memory slave.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DMEM_DEPTH  = 256;
  localparam int DMEM_AW     = 8;
  localparam int WAIT_CYCLES = 2;

  localparam logic WEN_WRITE = 1'b0;

  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic be_is_legal(input logic [3:0] be);
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_LO, BE_HI, BE_WORD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a data-memory requester and dmem_responder.
// Handshake: a request is taken on the edge that ends an IDLE cycle with d_mem_req=1;
// the access finishes with a single-cycle d_mem_ack, and d_mem_err/d_mem_dout are only meaningful with it.
interface dmem_responder_if;
  logic        d_mem_req;
  logic        d_mem_wen;
  logic [3:0]  d_mem_be;
  logic [11:0] d_mem_addr;
  logic [31:0] d_mem_di;
  logic [31:0] d_mem_dout;
  logic        d_mem_ack;
  logic        d_mem_err;
  logic        busy;

  modport master (
    output d_mem_req, d_mem_wen, d_mem_be, d_mem_addr, d_mem_di,
    input  d_mem_dout, d_mem_ack, d_mem_err, busy
  );

  modport slave (
    input  d_mem_req, d_mem_wen, d_mem_be, d_mem_addr, d_mem_di,
    output d_mem_dout, d_mem_ack, d_mem_err, busy
  );
endinterface

// File: rtl/dmem_array.sv
// 256 x 32 single-port storage: byte-lane synchronous write, registered read, no reset.
module dmem_array
  import dmem_pkg::*;
(
  input  logic               clk,
  input  logic [3:0]         we,
  input  logic               re,
  input  logic [DMEM_AW-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [31:0] mem [DMEM_DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: IDLE/WAIT/RESP FSM in front of dmem_array.
// Define DMEM_RESPONDER_WAIT_STATE_EN to add two WAIT cycles between accept and RESP.
module dmem_responder
  import dmem_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus,
  output state_t          state
);

  state_t      state_q, state_next;
  logic        commit;
  logic        op_wen;
  logic [3:0]  op_be;
  logic [9:0]  op_addr;
  logic [31:0] op_di;
  logic        legal, is_read;
  logic [3:0]  array_we;
  logic        array_re;
  logic [31:0] rdata, mask_q;
  logic        err_q;
  logic        unused_addr_hi;

  // Upper address bits only alias the 1 KiB window.
  assign unused_addr_hi = ^bus.d_mem_addr[11:10];

`ifdef DMEM_RESPONDER_WAIT_STATE_EN
  logic [1:0]  cnt_q;
  logic        wen_q;
  logic [3:0]  be_q;
  logic [9:0]  addr_q;
  logic [31:0] di_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
    end else if (state_q == IDLE && bus.d_mem_req) begin
      cnt_q  <= 2'(WAIT_CYCLES - 1);
      wen_q  <= bus.d_mem_wen;
      be_q   <= bus.d_mem_be;
      addr_q <= bus.d_mem_addr[9:0];
      di_q   <= bus.d_mem_di;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - 2'd1;
    end
  end

  assign op_wen  = wen_q;
  assign op_be   = be_q;
  assign op_addr = addr_q;
  assign op_di   = di_q;
`else
  // Without wait states the access commits on the accept edge itself.
  assign op_wen  = bus.d_mem_wen;
  assign op_be   = bus.d_mem_be;
  assign op_addr = bus.d_mem_addr[9:0];
  assign op_di   = bus.d_mem_di;
`endif

  always_comb begin
    state_next = state_q;
    commit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.d_mem_req) begin
`ifdef DMEM_RESPONDER_WAIT_STATE_EN
          state_next = WAIT;
`else
          state_next = RESP;
          commit     = 1'b1;
`endif
        end
      end
      WAIT: begin
`ifdef DMEM_RESPONDER_WAIT_STATE_EN
        if (cnt_q == 2'd0) begin
          state_next = RESP;
          commit     = 1'b1;
        end
`else
        state_next = IDLE;
`endif
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign legal    = (op_addr[1:0] == 2'b00) && be_is_legal(op_be);
  assign is_read  = (op_wen != WEN_WRITE);
  // Reset on the commit edge wins: nothing reaches the array.
  assign array_we = (commit && !rst && legal && !is_read) ? op_be : 4'b0000;
  assign array_re = commit && !rst && legal && is_read;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_next;
      if (commit) begin
        err_q  <= !legal;
        mask_q <= (legal && is_read) ? lane_mask(op_be) : '0;
      end
    end
  end

  dmem_array u_array (
    .clk   (clk),
    .we    (array_we),
    .re    (array_re),
    .addr  (op_addr[9:2]),
    .wdata (op_di),
    .rdata (rdata)
  );

  assign bus.d_mem_ack  = (state_q == RESP);
  assign bus.d_mem_err  = (state_q == RESP) && err_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.d_mem_dout = rdata & mask_q;
  assign state          = state_q;

endmodule
